// File: rtl/inv_key_sched_pkg.sv
// Shared definitions for the AES-128 inverse key schedule: FSM state encoding,
// forward S-box table, round-constant lookup and the GF(2^8) multiplies needed
// by InvMixColumns. The optional InvMixColumns output transform is enabled by
// defining INV_KEY_SCHED_EQ_INV_CIPHER_EN.
package inv_key_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Round constant Rcon[r] for r = 1..10; round 0 has no constant.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Multiply by 2 modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_x2(input logic [7:0] a);
    gf_x2 = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_x9(input logic [7:0] a);
    gf_x9 = gf_x2(gf_x2(gf_x2(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_xb(input logic [7:0] a);
    gf_xb = gf_x2(gf_x2(gf_x2(a))) ^ gf_x2(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_xd(input logic [7:0] a);
    gf_xd = gf_x2(gf_x2(gf_x2(a))) ^ gf_x2(gf_x2(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_xe(input logic [7:0] a);
    gf_xe = gf_x2(gf_x2(gf_x2(a))) ^ gf_x2(gf_x2(a)) ^ gf_x2(a);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
module aes_sbox
  import inv_key_sched_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 inverse key schedule. Latches the round-10 key on start and streams
// round keys 10 down to 0 over a valid/ready interface, one per cycle when the
// consumer is always ready. Defining INV_KEY_SCHED_EQ_INV_CIPHER_EN applies
// InvMixColumns to the emitted keys of rounds 9..1 (equivalent inverse cipher);
// the internal recurrence always runs on the plain keys.
module inv_key_sched
  import inv_key_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [0:15][7:0] key_last,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [0:15][7:0] rk,
  output logic [3:0]       rk_round,
  output logic             done
);

  state_t           state_q, state_nxt;
  logic [0:15][7:0] key_q;
  logic [0:15][7:0] key_nxt;
  logic [3:0]       round_q;
  logic             done_q;
  logic             handshake;
  logic             last_round;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w0_nxt, w1_nxt, w2_nxt, w3_nxt;
  logic [31:0] rot_word, sub_word;

  assign handshake  = (state_q == ST_EMIT) && rk_ready;
  assign last_round = (round_q == 4'd0);

  // One step backwards through the key expansion: round r -> round r-1.
  assign w0 = key_q[0:3];
  assign w1 = key_q[4:7];
  assign w2 = key_q[8:11];
  assign w3 = key_q[12:15];

  assign w3_nxt   = w3 ^ w2;
  assign w2_nxt   = w2 ^ w1;
  assign w1_nxt   = w1 ^ w0;
  assign rot_word = {w3_nxt[23:0], w3_nxt[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .din  (rot_word[31-8*i -: 8]),
      .dout (sub_word[31-8*i -: 8])
    );
  end

  assign w0_nxt  = w0 ^ sub_word ^ {rcon(round_q), 24'h000000};
  assign key_nxt = {w0_nxt, w1_nxt, w2_nxt, w3_nxt};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic: start only matters in IDLE; round-0 handshake ends EMIT.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start) state_nxt = ST_EMIT;
      ST_EMIT: if (handshake && last_round) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Key register, round counter and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= handshake && last_round;
      if (state_q == ST_IDLE && start) begin
        key_q   <= key_last;
        round_q <= LAST_ROUND;
      end else if (handshake && !last_round) begin
        key_q   <= key_nxt;
        round_q <= round_q - 4'd1;
      end
    end
  end

  assign busy     = (state_q == ST_EMIT);
  assign rk_valid = (state_q == ST_EMIT);
  assign rk_round = round_q;
  assign done     = done_q;

`ifdef INV_KEY_SCHED_EQ_INV_CIPHER_EN
  // Output path: InvMixColumns per column for the middle rounds only.
  always_comb begin
    rk = key_q;
    if (round_q != 4'd0 && round_q != LAST_ROUND) begin
      for (int c = 0; c < 4; c++) begin
        rk[4*c]   = gf_xe(key_q[4*c]) ^ gf_xb(key_q[4*c+1]) ^
                    gf_xd(key_q[4*c+2]) ^ gf_x9(key_q[4*c+3]);
        rk[4*c+1] = gf_x9(key_q[4*c]) ^ gf_xe(key_q[4*c+1]) ^
                    gf_xb(key_q[4*c+2]) ^ gf_xd(key_q[4*c+3]);
        rk[4*c+2] = gf_xd(key_q[4*c]) ^ gf_x9(key_q[4*c+1]) ^
                    gf_xe(key_q[4*c+2]) ^ gf_xb(key_q[4*c+3]);
        rk[4*c+3] = gf_xb(key_q[4*c]) ^ gf_xd(key_q[4*c+1]) ^
                    gf_x9(key_q[4*c+2]) ^ gf_xe(key_q[4*c+3]);
      end
    end
  end
`else
  assign rk = key_q;
`endif

endmodule

// File: tb/tb_inv_key_sched.sv
// Self-checking bench for inv_key_sched. Expected round keys come from a
// forward AES-128 key expansion of the known round-0 key, queued in emission
// order and popped on each handshake; fixed vectors anchor rounds 9 and 0.
module tb_inv_key_sched;
  import inv_key_sched_pkg::SBOX;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
  } exp_t;

  localparam logic [127:0] K10_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K9_A  = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] K0_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K0_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_JUNK = 128'hffeeddccbbaa99887766554433221100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [0:15][7:0] key_last;
  logic             busy;
  logic             rk_valid;
  logic             rk_ready;
  logic [0:15][7:0] rk;
  logic [3:0]       rk_round;
  logic             done;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inv_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_last (key_last),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_round (rk_round),
    .done     (done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] imc_ref(input logic [127:0] k);
    logic [127:0] o;
    logic [7:0] s0, s1, s2, s3;
    for (int c = 0; c < 4; c++) begin
      s0 = k[127-32*c -: 8];
      s1 = k[119-32*c -: 8];
      s2 = k[111-32*c -: 8];
      s3 = k[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09);
      o[119-32*c -: 8] = gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d);
      o[111-32*c -: 8] = gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b);
      o[103-32*c -: 8] = gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] emitted(input int r, input logic [127:0] k);
`ifdef INV_KEY_SCHED_EQ_INV_CIPHER_EN
    if (r >= 1 && r <= 9) return imc_ref(k);
`endif
    return k;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r = {w[23:0], w[31:24]};
    return {SBOX[r[31:24]], SBOX[r[23:16]], SBOX[r[15:8]], SBOX[r[7:0]]};
  endfunction

  // Forward expansion from the round-0 key; queue rounds 10..0.
  task automatic load_expected(input logic [127:0] k0);
    logic [31:0] w[0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    exp_t        e;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_rot(t) ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    sb_q.delete();
    for (int r = 10; r >= 0; r--) begin
      e.round = 4'(r);
      e.key   = emitted(r, {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
      sb_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [127:0] key);
    @(negedge clk);
    start = 1'b1;
    key_last = key;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drains the queue; mode 0 = always ready, mode 1 = ready pattern 1,0,0,1.
  // Returns at the negedge following the round-0 handshake (the done cycle),
  // or after applying reset when rk_round reaches abort_round.
  task automatic consume(input int mode, input int poke_round, input int abort_round,
                         input bit chk_anchor, input logic [127:0] r9_anchor,
                         input logic [127:0] r0_anchor);
    int           cycles = 0;
    int           phase = 0;
    bit           held = 1'b0;
    logic [127:0] prev_rk = '0;
    logic [3:0]   prev_round = '0;
    exp_t         e;
    while (sb_q.size() > 0) begin
      if (cycles >= 200) begin
        checks++;
        errors++;
        $error("FAIL timeout: observed no completion after %0d cycles expected 11 handshakes", cycles);
        return;
      end
      check("rk_valid_in_emit", rk_valid, 1'b1);
      check("busy_in_emit", busy, 1'b1);
      if (held) begin
        check("stall_rk_stable", rk, prev_rk);
        check("stall_round_stable", rk_round, prev_round);
      end
      if (abort_round >= 0 && int'(rk_round) == abort_round) begin
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_valid", rk_valid, 1'b0);
        check("async_rst_rk", rk, '0);
        check("async_rst_round", rk_round, 4'd0);
        @(negedge clk);
        check("rst_next_busy", busy, 1'b0);
        check("rst_next_valid", rk_valid, 1'b0);
        check("rst_next_rk", rk, '0);
        check("rst_next_done", done, 1'b0);
        rst_n = 1'b1;
        sb_q.delete();
        return;
      end
      rk_ready = (mode == 0) ? 1'b1 : (phase == 0 || phase == 3);
      phase = (phase + 1) % 4;
      if (poke_round >= 0 && int'(rk_round) == poke_round) begin
        start = 1'b1;
        key_last = K_JUNK;
      end
      if (rk_ready) begin
        e = sb_q.pop_front();
        check("rk_round", rk_round, e.round);
        check("rk_value", rk, e.key);
        if (chk_anchor && e.round == 4'd9) check("rk_round9_vector", rk, emitted(9, r9_anchor));
        if (e.round == 4'd0) check("rk_round0_vector", rk, r0_anchor);
        held = 1'b0;
      end else begin
        held = 1'b1;
        prev_rk = rk;
        prev_round = rk_round;
      end
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end
    check("done_pulse", done, 1'b1);
    check("busy_after_round0", busy, 1'b0);
    check("valid_after_round0", rk_valid, 1'b0);
  endtask

  task automatic done_ends;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_no_valid", rk_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key_last = '0;
    rk_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_valid", rk_valid, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_round", rk_round, 4'd0);
    check("reset_rk", rk, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", rk_valid, 1'b0);

    // Full-rate schedule on the FIPS-197 key.
    load_expected(K0_A);
    do_start(K10_A);
    check("first_round_is_10", rk_round, 4'd10);
    check("round10_unmodified", rk, K10_A);
    consume(0, -1, -1, 1'b1, K9_A, K0_A);
    done_ends();

    // Backpressure with rk_ready 1,0,0,1.
    load_expected(K0_B);
    do_start(K10_B);
    consume(1, -1, -1, 1'b0, '0, K0_B);
    done_ends();

    // start while busy at round 5 is ignored.
    load_expected(K0_A);
    do_start(K10_A);
    consume(0, 5, -1, 1'b1, K9_A, K0_A);
    done_ends();

    // start coincident with the round-0 handshake is ignored.
    load_expected(K0_A);
    do_start(K10_A);
    consume(0, 0, -1, 1'b0, '0, K0_A);
    check("start_at_round0_ignored", rk_valid, 1'b0);
    done_ends();

    // Reset at round 6 abandons the schedule; then a clean rerun.
    load_expected(K0_A);
    do_start(K10_A);
    consume(0, -1, 6, 1'b0, '0, K0_A);
    repeat (3) begin
      @(negedge clk);
      check("no_valid_after_abort", rk_valid, 1'b0);
    end
    load_expected(K0_A);
    do_start(K10_A);
    consume(0, -1, -1, 1'b1, K9_A, K0_A);
    done_ends();

    // start in the done cycle is accepted.
    load_expected(K0_A);
    do_start(K10_A);
    consume(0, -1, -1, 1'b0, '0, K0_A);
    load_expected(K0_B);
    start = 1'b1;
    key_last = K10_B;
    @(negedge clk);
    start = 1'b0;
    check("restart_valid", rk_valid, 1'b1);
    check("restart_round", rk_round, 4'd10);
    check("restart_rk", rk, K10_B);
    consume(0, -1, -1, 1'b0, '0, K0_B);
    done_ends();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
